// File: rtl/arbitro_mux2.sv
// Round-robin arbiter for two requesters sharing one 2:1 mux and an output register.
// Latency: request accepted with same-cycle ack; word appears in salida one clock later.
// Backpressure: while salida is full and salida_ready=0 no acks are issued and salida holds.

module Mux2to1Param #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);
    assign out = sel ? in1 : in0;
endmodule

module arbitro_mux2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] entrada0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] entrada1,
    output logic             ack1,
    output logic             sel,
    output logic [WIDTH-1:0] salida,
    output logic             salida_valid,
    input  logic             salida_ready,
    output logic             salida_origen
);
    typedef enum logic {
        LIBRE   = 1'b0,
        OCUPADO = 1'b1
    } estado_t;

    estado_t          state;
    estado_t          state_next;
    logic             ultimo;
    logic             sel_q;
    logic             aceptar;
    logic             grant_vld;
    logic             grant_idx;
    logic [WIDTH-1:0] mux_out;

    Mux2to1Param #(.WIDTH(WIDTH)) u_mux (
        .sel (sel),
        .in0 (entrada0),
        .in1 (entrada1),
        .out (mux_out)
    );

    // State register; reset empties the output slot immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LIBRE;
        end else begin
            state <= state_next;
        end
    end

    // Grant decision, acks and next state. When nothing is granted sel keeps the
    // last granted index so the mux select never glitches back to 0.
    always_comb begin
        aceptar    = (state == LIBRE) || ((state == OCUPADO) && salida_ready);
        grant_vld  = 1'b0;
        grant_idx  = sel_q;
        state_next = state;
        if (!reset && aceptar) begin
            if (req0 && req1) begin
                grant_vld = 1'b1;
                grant_idx = ~ultimo;
            end else if (req0) begin
                grant_vld = 1'b1;
                grant_idx = 1'b0;
            end else if (req1) begin
                grant_vld = 1'b1;
                grant_idx = 1'b1;
            end
        end
        if (grant_vld) begin
            state_next = OCUPADO;
        end else if ((state == OCUPADO) && salida_ready) begin
            state_next = LIBRE;
        end
    end

    assign ack0         = grant_vld && (grant_idx == 1'b0);
    assign ack1         = grant_vld && (grant_idx == 1'b1);
    assign sel          = grant_idx;
    assign salida_valid = (state == OCUPADO);

    // Capture the granted word and remember who won for the alternation pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            salida        <= '0;
            salida_origen <= 1'b0;
            ultimo        <= 1'b1;
            sel_q         <= 1'b0;
        end else if (grant_vld) begin
            salida        <= mux_out;
            salida_origen <= grant_idx;
            ultimo        <= grant_idx;
            sel_q         <= grant_idx;
        end
    end
endmodule

// File: tb/tb_arbitro_mux2.sv
// Directed bench for arbitro_mux2: a vector table walked cycle by cycle from reset,
// plus hand sequences for reset assertion mid-transfer and pointer recovery.
module tb_arbitro_mux2;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, salida_ready;
    logic [31:0] entrada0, entrada1;
    logic        ack0, ack1, sel, salida_valid, salida_origen;
    logic [31:0] salida;

    int checks = 0;
    int errors = 0;

    arbitro_mux2 #(.WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .req0          (req0),
        .entrada0      (entrada0),
        .ack0          (ack0),
        .req1          (req1),
        .entrada1      (entrada1),
        .ack1          (ack1),
        .sel           (sel),
        .salida        (salida),
        .salida_valid  (salida_valid),
        .salida_ready  (salida_ready),
        .salida_origen (salida_origen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0;
        logic [31:0] e0;
        logic        r1;
        logic [31:0] e1;
        logic        rdy;
        logic        a0;
        logic        a1;
        logic        s;
        logic [31:0] q;
        logic        v;
        logic        o;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r0, input logic [31:0] e0, input logic r1,
                       input logic [31:0] e1, input logic rdy, input logic a0,
                       input logic a1, input logic s, input logic [31:0] q,
                       input logic v, input logic o);
        vec_t t;
        t.r0 = r0; t.e0 = e0; t.r1 = r1; t.e1 = e1; t.rdy = rdy;
        t.a0 = a0; t.a1 = a1; t.s = s; t.q = q; t.v = v; t.o = o;
        vt.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //   r0  e0            r1  e1            rdy | a0 a1 sel  salida        v  o
        add(1, 32'hF0F0F0F0, 1, 32'h0F0F0F0F, 1,   1, 0, 0, 32'hF0F0F0F0, 1, 0);
        add(1, 32'hF0F0F0F0, 1, 32'h0F0F0F0F, 1,   0, 1, 1, 32'h0F0F0F0F, 1, 1);
        add(1, 32'hF0F0F0F0, 1, 32'h0F0F0F0F, 1,   1, 0, 0, 32'hF0F0F0F0, 1, 0);
        add(1, 32'hF0F0F0F0, 1, 32'h0F0F0F0F, 1,   0, 1, 1, 32'h0F0F0F0F, 1, 1);
        add(0, 32'h0,        0, 32'h0,        1,   0, 0, 1, 32'h0F0F0F0F, 0, 1);
        add(1, 32'hAAAAAAAA, 0, 32'h0,        1,   1, 0, 0, 32'hAAAAAAAA, 1, 0);
        add(0, 32'h0,        0, 32'h0,        1,   0, 0, 0, 32'hAAAAAAAA, 0, 0);
        add(1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1,   0, 1, 1, 32'hFFFFFFFF, 1, 1);
        add(1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1,   1, 0, 0, 32'hFFFFFFFF, 1, 0);
        add(1, 32'h55555555, 0, 32'h0,        1,   1, 0, 0, 32'h55555555, 1, 0);
        add(0, 32'h0,        1, 32'h12345678, 0,   0, 0, 0, 32'h55555555, 1, 0);
        add(0, 32'h0,        1, 32'h12345678, 0,   0, 0, 0, 32'h55555555, 1, 0);
        add(0, 32'h0,        1, 32'h12345678, 0,   0, 0, 0, 32'h55555555, 1, 0);
        add(0, 32'h0,        1, 32'h12345678, 1,   0, 1, 1, 32'h12345678, 1, 1);
        add(1, 32'hDEADBEEF, 0, 32'h0,        0,   0, 0, 1, 32'h12345678, 1, 1);
        add(0, 32'hDEADBEEF, 0, 32'h0,        1,   0, 0, 1, 32'h12345678, 0, 1);
        add(0, 32'h0,        1, 32'hCAFEBABE, 0,   0, 1, 1, 32'hCAFEBABE, 1, 1);
        add(1, 32'h13579BDF, 1, 32'h2468ACE0, 0,   0, 0, 1, 32'hCAFEBABE, 1, 1);
        add(1, 32'h13579BDF, 1, 32'h2468ACE0, 1,   1, 0, 0, 32'h13579BDF, 1, 0);

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; salida_ready = 1'b0;
        entrada0 = '0; entrada1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset salida", salida, 32'h0);
        check("reset valid", 32'(salida_valid), 32'h0);
        check("reset origen", 32'(salida_origen), 32'h0);
        req0 = 1'b1; req1 = 1'b1; salida_ready = 1'b1;
        #1;
        check("reset ack0 forced", 32'(ack0), 32'h0);
        check("reset ack1 forced", 32'(ack1), 32'h0);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vt.size(); i++) begin
            req0 = vt[i].r0; entrada0 = vt[i].e0;
            req1 = vt[i].r1; entrada1 = vt[i].e1;
            salida_ready = vt[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d ack0", i), 32'(ack0), 32'(vt[i].a0));
            check($sformatf("vec%0d ack1", i), 32'(ack1), 32'(vt[i].a1));
            check($sformatf("vec%0d sel", i), 32'(sel), 32'(vt[i].s));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d salida", i), salida, vt[i].q);
            check($sformatf("vec%0d valid", i), 32'(salida_valid), 32'(vt[i].v));
            check($sformatf("vec%0d origen", i), 32'(salida_origen), 32'(vt[i].o));
        end

        // Reset asserted between edges while salida holds a word.
        req0 = 1'b1; entrada0 = 32'h11111111; req1 = 1'b0; salida_ready = 1'b1;
        #1;
        check("pre-reset ack0", 32'(ack0), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        check("async reset valid", 32'(salida_valid), 32'h0);
        check("async reset salida", salida, 32'h0);
        check("async reset origen", 32'(salida_origen), 32'h0);
        check("async reset ack0", 32'(ack0), 32'h0);
        check("async reset ack1", 32'(ack1), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        req0 = 1'b1; entrada0 = 32'h77777777;
        req1 = 1'b1; entrada1 = 32'h88888888;
        #1;
        check("post-reset pointer ack0", 32'(ack0), 32'h1);
        check("post-reset pointer ack1", 32'(ack1), 32'h0);
        @(posedge clk);
        #1;
        check("post-reset salida", salida, 32'h77777777);
        check("post-reset valid", 32'(salida_valid), 32'h1);
        check("post-reset origen", 32'(salida_origen), 32'h0);
        req0 = 1'b0; req1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
